// File: rtl/sub_seq.sv
// sub_seq: multi-cycle WIDTH-bit subtractor computing a - b - bin one 4-bit slice per cycle,
// least-significant slice first. The borrow is held between slices as an active-high carry
// (carry = ~borrow), so each slice is an adder: a_k + ~b_k + carry.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   operands valid
//   in_ready_o   block can accept operands (IDLE only)
//   a_i, b_i     minuend, subtrahend
//   bin_i        borrow-in
//   out_valid_o  diff_o/bout_o/zero_o valid (DONE only)
//   out_ready_i  consumer accepts the result
//   diff_o       (a - b - bin) mod 2^WIDTH
//   bout_o       borrow-out, 1 when a < b + bin (unsigned)
//   zero_o       diff_o == 0
module sub_seq #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             bin_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] diff_o,
   output logic             bout_o,
   output logic             zero_o
);

   localparam int unsigned N    = WIDTH / 4;
   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e            state_q;
   logic [WIDTH-1:0]  a_q, b_q, diff_q;
   logic              carry_q, bout_q, zero_q;
   logic [IdxW-1:0]   idx_q;

   logic [3:0]        a_sl, b_sl, p, g, s;
   logic [4:0]        c;
   logic [WIDTH-1:0]  diff_nxt;
   logic              last_slice;

   // One 4-bit carry-lookahead slice on the inverted subtrahend.
   always_comb begin
      a_sl = 4'(a_q >> {idx_q, 2'b00});
      b_sl = 4'(b_q >> {idx_q, 2'b00});
      p    = a_sl ^ ~b_sl;
      g    = a_sl & ~b_sl;
      c[0] = carry_q;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      s    = p ^ c[3:0];
      // The result register is cleared on accept, so OR-ing places the slice in its empty field.
      diff_nxt   = diff_q | (WIDTH'(s) << {idx_q, 2'b00});
      last_slice = (idx_q == IdxW'(N - 1));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid_i) begin
                  a_q     <= a_i;
                  b_q     <= b_i;
                  carry_q <= ~bin_i;
                  idx_q   <= '0;
                  diff_q  <= '0;
                  bout_q  <= 1'b0;
                  zero_q  <= 1'b0;
                  state_q <= StCalc;
               end
            end
            StCalc: begin
               diff_q  <= diff_nxt;
               carry_q <= c[4];
               if (last_slice) begin
                  idx_q   <= '0;
                  bout_q  <= ~c[4];
                  zero_q  <= (diff_nxt == '0);
                  state_q <= StDone;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            StDone: begin
               if (out_ready_i) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Handshake flags depend on state only.
   assign in_ready_o  = (state_q == StIdle);
   assign out_valid_o = (state_q == StDone);
   assign diff_o      = diff_q;
   assign bout_o      = bout_q;
   assign zero_o      = zero_q;

endmodule

// File: tb/tb_sub_seq.sv
// Testbench for sub_seq (WIDTH = 16): directed corner cases, backpressure, reset mid-operation,
// and randomized operands with random output stalls checked against an arithmetic model.
module tb_sub_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0, b = '0;
   logic        bin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] diff;
   logic        bout, zero;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sub_seq #(.WIDTH(16)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a),
      .b_i         (b),
      .bin_i       (bin),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .diff_o      (diff),
      .bout_o      (bout),
      .zero_o      (zero)
   );

   // Reference: {borrow, difference} from plain integer arithmetic.
   function automatic logic [16:0] model(input logic [15:0] ta, input logic [15:0] tb,
                                         input logic tbin);
      int unsigned ua = ta;
      int unsigned ub = tb;
      int unsigned ubi = tbin;
      int unsigned d = (ua + 32'h10000 - ub - ubi) & 32'hFFFF;
      logic bo = (ua < ub + ubi);
      return {bo, 16'(d)};
   endfunction

   // Present operands at a falling edge once in_ready is seen; returns 1 ns after the accept edge.
   task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL in_ready_wait: in_ready=%b required 1", in_ready);
      end
      a = ta; b = tb; bin = tbin; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
   endtask

   // Counts edges after the accept edge until out_valid is seen (bounded).
   task automatic wait_valid(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      vectors++;
      if ({in_ready, out_valid, diff, bout, zero} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset: rdy=%b vld=%b diff=%h bout=%b zero=%b required 1 0 0000 0 0",
                  in_ready, out_valid, diff, bout, zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [15:0] ta [5] = '{16'h1234, 16'h0000, 16'h0000, 16'h1000, 16'h5555};
      logic [15:0] tb [5] = '{16'h0234, 16'h0001, 16'h0000, 16'h0001, 16'h5554};
      logic        tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [15:0] ed [5] = '{16'h1000, 16'hFFFF, 16'hFFFF, 16'h0FFF, 16'h0000};
      logic        eb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic        ez [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int lat;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         start_op(ta[i], tb[i], tc[i]);
         wait_valid(lat);
         vectors++;
         if (lat !== 4) begin
            miscompares++;
            $display("FAIL dir%0d_latency: got %0d required 4", i, lat);
         end
         vectors++;
         if ({diff, bout, zero} !== {ed[i], eb[i], ez[i]}) begin
            miscompares++;
            $display("FAIL dir%0d_result: diff=%h bout=%b zero=%b required %h %b %b",
                     i, diff, bout, zero, ed[i], eb[i], ez[i]);
         end
         @(posedge clk);
         #1;
         vectors++;
         if ({in_ready, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL dir%0d_idle: rdy=%b vld=%b required 1 0", i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      out_ready = 1'b0;
      start_op(16'h1234, 16'h0234, 1'b0);
      wait_valid(lat);
      vectors++;
      if (lat !== 4) begin
         miscompares++;
         $display("FAIL bp_latency: got %0d required 4", lat);
      end
      @(negedge clk);
      a = 16'hAAAA; b = 16'h5555; bin = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if ({out_valid, in_ready, diff, bout, zero} !== {1'b1, 1'b0, 16'h1000, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_hold%0d: vld=%b rdy=%b diff=%h bout=%b zero=%b required 1 0 1000 0 0",
                     i, out_valid, in_ready, diff, bout, zero);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if ({in_ready, out_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL bp_release: rdy=%b vld=%b required 1 0", in_ready, out_valid);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_accept: rdy=%b required 0", in_ready);
      end
      wait_valid(lat);
      vectors++;
      if (lat !== 4 || {diff, bout, zero} !== {16'h5554, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL bp_next: lat=%0d diff=%h bout=%b zero=%b required 4 5554 0 0",
                  lat, diff, bout, zero);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int lat;
      out_ready = 1'b1;
      start_op(16'hFFFF, 16'h1111, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({in_ready, out_valid, diff, bout, zero} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL rst_mid: rdy=%b vld=%b diff=%h bout=%b zero=%b required 1 0 0000 0 0",
                  in_ready, out_valid, diff, bout, zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
      start_op(16'hFFFF, 16'h0001, 1'b0);
      wait_valid(lat);
      vectors++;
      if (lat !== 4 || {diff, bout, zero} !== {16'hFFFE, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL rst_after: lat=%0d diff=%h bout=%b zero=%b required 4 fffe 0 0",
                  lat, diff, bout, zero);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      logic [15:0] ta, tb;
      logic        tc;
      logic [16:0] exp;
      int lat, k;
      for (int i = 0; i < 1000; i++) begin
         ta  = 16'($urandom);
         tb  = ($urandom_range(0, 7) == 0) ? ta : 16'($urandom);
         tc  = 1'($urandom);
         exp = model(ta, tb, tc);
         out_ready = 1'($urandom_range(0, 1));
         start_op(ta, tb, tc);
         wait_valid(lat);
         vectors++;
         if (lat !== 4) begin
            miscompares++;
            $display("FAIL rnd%0d_latency: got %0d required 4", i, lat);
         end
         vectors++;
         if ({diff, bout, zero} !== {exp[15:0], exp[16], exp[15:0] == 16'h0}) begin
            miscompares++;
            $display("FAIL rnd%0d_result: a=%h b=%h bin=%b diff=%h bout=%b zero=%b required %h %b %b",
                     i, ta, tb, tc, diff, bout, zero, exp[15:0], exp[16], exp[15:0] == 16'h0);
         end
         if (!out_ready) begin
            k = $urandom_range(1, 4);
            repeat (k) @(negedge clk);
            vectors++;
            if ({out_valid, in_ready, diff, bout} !== {1'b1, 1'b0, exp[15:0], exp[16]}) begin
               miscompares++;
               $display("FAIL rnd%0d_stall: vld=%b rdy=%b diff=%h bout=%b required 1 0 %h %b",
                        i, out_valid, in_ready, diff, bout, exp[15:0], exp[16]);
            end
            out_ready = 1'b1;
         end
         @(posedge clk);
         #1;
         vectors++;
         if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rnd%0d_handshake: vld=%b required 0", i, out_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
